// File: rtl/header_dispatcher.sv
// rtl/header_dispatcher.sv - node-0 job dispatcher: header broadcast to PEs and FOUND result collection
// Optional watchdog: define HDR_DISPATCH_TIMEOUT_EN (adds TIMEOUT parameter and WAIT-state counter).
module header_dispatcher #(
    parameter int NUM_PE       = 5,
    parameter int INIT_CREDITS = 8
`ifdef HDR_DISPATCH_TIMEOUT_EN
    ,parameter logic [31:0] TIMEOUT = 32'd100000000
`endif
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic [639:0] header,
    input  logic         header_valid,
    output logic         header_ready,
    output logic [72:0]  putFlit,
    output logic         EN_putFlit,
    input  logic [2:0]   net_credit,
    input  logic [72:0]  getFlit,
    output logic         send_credit,
    output logic [2:0]   credit_in,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [4:0]   found_pe,
    output logic [63:0]  found_cycles,
    output logic         busy,
    output logic         timeout
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] CRED_MAX = 4'(INIT_CREDITS);
    localparam logic [4:0] LAST_PE  = 5'(NUM_PE);

    state_t      state, state_nxt;
    logic [63:0] hdr_w [10];
    logic [3:0]  word;
    logic [4:0]  pe;
    logic [3:0]  credits;
    logic        job_start;
    logic        last_flit;
    logic        cred_ret;
    logic        wd_expire;

    logic        rx_valid, rx_tail;
    logic [63:0] rx_data;
    logic [1:0]  rx_idx;
    logic        rx_good;
    logic [31:0] nonce_q;
    logic        result_ok;
    logic [4:0]  pe_of_nonce;
    logic        unused_bits;

    assign last_flit = (pe == LAST_PE) && (word == 4'd9);
    assign cred_ret  = net_credit[2] && (net_credit[1:0] == 2'd0);

    always_ff @(posedge sys_clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        header_ready = 1'b0;
        busy         = 1'b0;
        EN_putFlit   = 1'b0;
        job_start    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                header_ready = 1'b1;
                if (header_valid) begin
                    job_start = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                busy       = 1'b1;
                EN_putFlit = (credits != 4'd0);
                if (EN_putFlit && last_flit) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // found may already be set by a result that overtook the dispatch
                if (found || wd_expire) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign putFlit = EN_putFlit ? {1'b1, (word == 4'd9), pe, 2'b00, hdr_w[word]} : 73'd0;

    always_ff @(posedge sys_clk) begin
        if (job_start) begin
            for (int k = 0; k < 10; k++) hdr_w[k] <= header[64*k +: 64];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            word <= 4'd0;
            pe   <= 5'd0;
        end else if (job_start) begin
            word <= 4'd0;
            pe   <= 5'd1;
        end else if (EN_putFlit) begin
            if (word == 4'd9) begin
                word <= 4'd0;
                pe   <= pe + 5'd1;
            end else begin
                word <= word + 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset)                                          credits <= CRED_MAX;
        else if (EN_putFlit && !cred_ret)                    credits <= credits - 4'd1;
        else if (!EN_putFlit && cred_ret && credits < CRED_MAX) credits <= credits + 4'd1;
    end

    assign rx_valid    = getFlit[72];
    assign rx_tail     = getFlit[71];
    assign rx_data     = getFlit[63:0];
    assign unused_bits = ^getFlit[70:66];
    assign result_ok   = rx_valid && rx_tail && (rx_idx == 2'd2) && rx_good;
    assign pe_of_nonce = 5'(nonce_q % 32'(NUM_PE)) + 5'd1;

    // Every ejected flit is returned as a credit, whether or not the packet is kept
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            send_credit <= 1'b0;
            credit_in   <= 3'd0;
            rx_idx      <= 2'd0;
            rx_good     <= 1'b0;
            nonce_q     <= 32'd0;
        end else begin
            send_credit <= rx_valid;
            credit_in   <= rx_valid ? {1'b1, getFlit[65:64]} : 3'd0;
            if (rx_valid) begin
                rx_idx <= rx_tail ? 2'd0 : rx_idx + 2'd1;
                if (rx_idx == 2'd0) rx_good <= (rx_data == 64'h1);
                if (rx_idx == 2'd1) nonce_q <= rx_data[31:0];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            found        <= 1'b0;
            found_nonce  <= 32'd0;
            found_pe     <= 5'd0;
            found_cycles <= 64'd0;
        end else if (job_start) begin
            found <= 1'b0;
        end else if (result_ok && !found) begin
            found        <= 1'b1;
            found_nonce  <= nonce_q;
            found_pe     <= pe_of_nonce;
            found_cycles <= rx_data;
        end
    end

`ifdef HDR_DISPATCH_TIMEOUT_EN
    logic [31:0] wd_cnt;

    assign wd_expire = (state == S_WAIT) && (wd_cnt == TIMEOUT - 32'd1);

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            wd_cnt  <= 32'd0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 32'd1 : 32'd0;
            if (job_start)               timeout <= 1'b0;
            else if (wd_expire && !found) timeout <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule
